// File: rtl/fifo_scoreboard_checker.sv
// In-order push/pop scoreboard for a FIFO-like DUT: compares every pop against the
// oldest pushed entry and tracks mismatches, underflows, overflow and worst-case latency.
module fifo_scoreboard_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cg,
    input  logic                    i_clear,
    input  logic                    i_pushed,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_popped,
    input  logic [WIDTH-1:0]        i_rdata,
    output logic [$clog2(DEPTH):0]  o_nOutstanding,
    output logic [CNT_W-1:0]        o_nMismatch,
    output logic [CNT_W-1:0]        o_nUnderflow,
    output logic [CNT_W-1:0]        o_maxLatency,
    output logic [WIDTH-1:0]        o_firstExp,
    output logic [WIDTH-1:0]        o_firstAct,
    output logic                    o_overflow,
    output logic                    o_error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_CHECK      = 1'b0;
    localparam logic [0:0] ST_OVERFLOWED = 1'b1;

    logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   ts_q, ts_d;
    logic [CNT_W-1:0]   mism_q, mism_d, under_q, under_d, maxlat_q, maxlat_d;
    logic [WIDTH-1:0]   fexp_q, fexp_d, fact_q, fact_d;
    logic               ovf_q, ovf_d, err_q, err_d;
    logic [0:0]         state_q, state_d;

    logic [WIDTH-1:0]   data_mem_q [DEPTH];
    logic [CNT_W-1:0]   ts_mem_q   [DEPTH];

    logic               empty, full, do_pop, do_push, wr_en;
    logic [WIDTH-1:0]   head_data;
    logic [CNT_W-1:0]   head_ts, lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_data = data_mem_q[rptr_q[AW-1:0]];
    assign head_ts   = ts_mem_q[rptr_q[AW-1:0]];
    assign lat       = ts_q - head_ts;
    // A pop only sees the pre-cycle queue; a push into a full queue is accepted only alongside a real dequeue.
    assign do_pop    = i_popped && !empty;
    assign do_push   = i_pushed && (!full || do_pop);
    assign wr_en     = i_cg && !i_clear && do_push;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ts_d     = ts_q;
        mism_d   = mism_q;
        under_d  = under_q;
        maxlat_d = maxlat_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        state_d  = state_q;
        if (i_cg) begin
            if (i_clear) begin
                wptr_d   = '0;
                rptr_d   = '0;
                ts_d     = '0;
                mism_d   = '0;
                under_d  = '0;
                maxlat_d = '0;
                fexp_d   = '0;
                fact_d   = '0;
                ovf_d    = 1'b0;
                err_d    = 1'b0;
                state_d  = ST_CHECK;
            end else begin
                ts_d = ts_q + CNT_W'(1);
                if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
                if (do_push) wptr_d = wptr_q + (AW+1)'(1);
                if (i_pushed && !do_push) begin
                    ovf_d   = 1'b1;
                    state_d = ST_OVERFLOWED;
                end
                // Once an entry has been dropped the streams are misaligned, so comparisons stop.
                if (state_q == ST_CHECK) begin
                    if (do_pop) begin
                        if (i_rdata != head_data) begin
                            mism_d = sat_inc(mism_q);
                            if (mism_q == '0) begin
                                fexp_d = head_data;
                                fact_d = i_rdata;
                            end
                        end
                        if (lat > maxlat_q) maxlat_d = lat;
                    end else if (i_popped) begin
                        under_d = sat_inc(under_q);
                    end
                end
                err_d = ovf_d | (mism_d != '0) | (under_d != '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            ts_q     <= '0;
            mism_q   <= '0;
            under_q  <= '0;
            maxlat_q <= '0;
            fexp_q   <= '0;
            fact_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= ST_CHECK;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ts_q     <= ts_d;
            mism_q   <= mism_d;
            under_q  <= under_d;
            maxlat_q <= maxlat_d;
            fexp_q   <= fexp_d;
            fact_q   <= fact_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    // Entry storage holds no control state, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            data_mem_q[wptr_q[AW-1:0]] <= i_wdata;
            ts_mem_q[wptr_q[AW-1:0]]   <= ts_q;
        end
    end

    assign o_nOutstanding = wptr_q - rptr_q;
    assign o_nMismatch    = mism_q;
    assign o_nUnderflow   = under_q;
    assign o_maxLatency   = maxlat_q;
    assign o_firstExp     = fexp_q;
    assign o_firstAct     = fact_q;
    assign o_overflow     = ovf_q;
    assign o_error        = err_q;
endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Bench for fifo_scoreboard_checker: a queue tracks the entries the DUT should hold,
// and each scenario task checks the counters and flags it expects.
module tb_fifo_scoreboard_checker;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cg, clear, pushed, popped;
    logic [WIDTH-1:0]       wdata, rdata;
    logic [$clog2(DEPTH):0] n_out;
    logic [CNT_W-1:0]       n_mism, n_under, max_lat;
    logic [WIDTH-1:0]       first_exp, first_act;
    logic                   ovf, err;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_scoreboard_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_cg(cg), .i_clear(clear),
        .i_pushed(pushed), .i_wdata(wdata), .i_popped(popped), .i_rdata(rdata),
        .o_nOutstanding(n_out), .o_nMismatch(n_mism), .o_nUnderflow(n_under),
        .o_maxLatency(max_lat), .o_firstExp(first_exp), .o_firstAct(first_act),
        .o_overflow(ovf), .o_error(err)
    );

    // One clock of stimulus; the scoreboard queue follows the pre-cycle-pop-then-push rule.
    task automatic cyc(input logic c, input logic clr, input logic push, input logic [WIDTH-1:0] wd,
                       input logic pop, input logic [WIDTH-1:0] rd);
        logic had;
        @(negedge clk);
        cg = c; clear = clr; pushed = push; wdata = wd; popped = pop; rdata = rd;
        @(posedge clk);
        #1;
        if (c) begin
            if (clr) exp_q.delete();
            else begin
                had = (exp_q.size() != 0);
                if (pop && had) void'(exp_q.pop_front());
                if (push && exp_q.size() < DEPTH) exp_q.push_back(wd);
            end
        end
        cg = 1'b1; clear = 1'b0; pushed = 1'b0; popped = 1'b0;
    endtask

    task automatic do_clear();
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (n_out !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", n_out); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%0b ovf=%0b want 0 0", err, ovf); end
        checks++; if (n_mism !== '0 || n_under !== '0 || max_lat !== '0) begin errors++; $display("FAIL reset_counters got %0d %0d %0d want 0 0 0", n_mism, n_under, max_lat); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        logic [WIDTH-1:0] hd;
        do_clear();
        cyc(1, 0, 1, 8'h11, 0, 8'h00);
        cyc(1, 0, 1, 8'h22, 0, 8'h00);
        cyc(1, 0, 1, 8'h33, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 0, 8'h00);
        checks++; if (n_out !== 3) begin errors++; $display("FAIL inorder_outstanding_mid got %0d want 3", n_out); end
        cyc(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            hd = exp_q[0];
            cyc(1, 0, 0, 8'h00, 1, hd);
        end
        checks++; if (n_mism !== 0) begin errors++; $display("FAIL inorder_mismatch got %0d want 0", n_mism); end
        checks++; if (n_out !== 0) begin errors++; $display("FAIL inorder_outstanding got %0d want 0", n_out); end
        checks++; if (max_lat !== 5) begin errors++; $display("FAIL inorder_latency got %0d want 5", max_lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL inorder_error got %0b want 0", err); end
    endtask

    task automatic test_mismatch();
        do_clear();
        cyc(1, 0, 1, 8'hA5, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 1, 8'h5A);
        checks++; if (n_mism !== 1) begin errors++; $display("FAIL mism_count got %0d want 1", n_mism); end
        checks++; if (first_exp !== 8'hA5 || first_act !== 8'h5A) begin errors++; $display("FAIL mism_first got %h/%h want a5/5a", first_exp, first_act); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mism_error got %0b want 1", err); end
        cyc(1, 0, 1, 8'h77, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 1, 8'h00);
        checks++; if (n_mism !== 2) begin errors++; $display("FAIL mism_count2 got %0d want 2", n_mism); end
        checks++; if (first_exp !== 8'hA5 || first_act !== 8'h5A) begin errors++; $display("FAIL mism_first_held got %h/%h want a5/5a", first_exp, first_act); end
    endtask

    task automatic test_underflow();
        do_clear();
        cyc(1, 0, 0, 8'h00, 1, 8'h12);
        checks++; if (n_under !== 1) begin errors++; $display("FAIL under_count got %0d want 1", n_under); end
        checks++; if (err !== 1'b1 || n_mism !== 0) begin errors++; $display("FAIL under_flags got err=%0b mism=%0d want 1 0", err, n_mism); end
        do_clear();
        cyc(1, 0, 1, 8'h44, 1, 8'h44);
        checks++; if (n_under !== 1) begin errors++; $display("FAIL under_samecycle got %0d want 1", n_under); end
        checks++; if (n_out !== 1 || n_out !== exp_q.size()) begin errors++; $display("FAIL under_samecycle_out got %0d want 1", n_out); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] hd;
        do_clear();
        cyc(1, 0, 1, 8'h01, 0, 8'h00);
        cyc(1, 0, 1, 8'h02, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            hd = exp_q[0];
            cyc(1, 0, 1, WIDTH'(8'h10 + i), 1, hd);
        end
        checks++; if (n_out !== 2) begin errors++; $display("FAIL b2b_outstanding got %0d want 2", n_out); end
        for (int i = 0; i < 2; i++) begin
            hd = exp_q[0];
            cyc(1, 0, 0, 8'h00, 1, hd);
        end
        checks++; if (n_mism !== 0 || max_lat !== 2) begin errors++; $display("FAIL b2b_result got mism=%0d lat=%0d want 0 2", n_mism, max_lat); end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] hd;
        do_clear();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, WIDTH'(i + 1), 0, 8'h00);
        checks++; if (n_out !== DEPTH) begin errors++; $display("FAIL full_count got %0d want 16", n_out); end
        hd = exp_q[0];
        cyc(1, 0, 1, 8'hEE, 1, hd);
        checks++; if (ovf !== 1'b0 || n_out !== DEPTH) begin errors++; $display("FAIL full_pushpop got ovf=%0b out=%0d want 0 16", ovf, n_out); end
        cyc(1, 0, 1, 8'hDD, 0, 8'h00);
        checks++; if (ovf !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL full_overflow got ovf=%0b err=%0b want 1 1", ovf, err); end
        checks++; if (n_out !== DEPTH) begin errors++; $display("FAIL full_dropped got %0d want 16", n_out); end
        hd = ~exp_q[0];
        cyc(1, 0, 0, 8'h00, 1, hd);
        cyc(1, 0, 0, 8'h00, 1, 8'h00);
        checks++; if (n_mism !== 0 || n_out !== exp_q.size()) begin errors++; $display("FAIL full_frozen got mism=%0d out=%0d want 0 %0d", n_mism, n_out, exp_q.size()); end
    endtask

    task automatic test_clear();
        do_clear();
        checks++; if (err !== 1'b0 || ovf !== 1'b0 || n_out !== 0) begin errors++; $display("FAIL clear_state got err=%0b ovf=%0b out=%0d want 0 0 0", err, ovf, n_out); end
        cyc(1, 0, 1, 8'h3C, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 1, 8'hC3);
        checks++; if (n_mism !== 1 || first_exp !== 8'h3C) begin errors++; $display("FAIL clear_check_state got mism=%0d exp=%h want 1 3c", n_mism, first_exp); end
    endtask

    task automatic test_clockgate();
        logic [WIDTH-1:0] hd;
        do_clear();
        cyc(0, 0, 1, 8'h99, 1, 8'h99);
        checks++; if (n_out !== 0 || n_under !== 0) begin errors++; $display("FAIL cg_idle got out=%0d under=%0d want 0 0", n_out, n_under); end
        cyc(1, 0, 1, 8'h66, 0, 8'h00);
        cyc(0, 0, 0, 8'h00, 1, 8'h00);
        checks++; if (n_out !== 1 || n_mism !== 0) begin errors++; $display("FAIL cg_pop_ignored got out=%0d mism=%0d want 1 0", n_out, n_mism); end
        hd = exp_q[0];
        cyc(1, 0, 0, 8'h00, 1, hd);
        checks++; if (n_out !== 0 || n_mism !== 0 || err !== 1'b0) begin errors++; $display("FAIL cg_resume got out=%0d mism=%0d err=%0b want 0 0 0", n_out, n_mism, err); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        cyc(1, 0, 1, 8'h55, 0, 8'h00);
        cyc(1, 0, 1, 8'h56, 1, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (n_out !== 0 || n_mism !== 0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_state got out=%0d mism=%0d err=%0b want 0 0 0", n_out, n_mism, err); end
        checks++; if (first_exp !== 0 || first_act !== 0 || max_lat !== 0) begin errors++; $display("FAIL rstmid_capture got %h %h %0d want 0 0 0", first_exp, first_act, max_lat); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cg = 1'b1; clear = 1'b0; pushed = 1'b0; popped = 1'b0;
        wdata = '0; rdata = '0;
        test_reset();
        test_in_order();
        test_mismatch();
        test_underflow();
        test_back_to_back();
        test_full();
        test_clear();
        test_clockgate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
